// File: rtl/demux_18.sv
// Registered 1-to-8 demultiplexer with a bit-serial word assembler.
// A data bit is steered into one of eight lanes by an explicit select or by a wrapping lane counter.
module demux_18 #(
    parameter logic [7:0] CLR_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       auto,
    input  logic [2:0] s,
    input  logic       d,
    output logic [7:0] y,
    output logic [2:0] cnt,
    output logic [7:0] q,
    output logic       done
);

    typedef enum logic [2:0] {
        FILL_0, FILL_1, FILL_2, FILL_3, FILL_4, FILL_5, FILL_6, FILL_7
    } fill_e;

    fill_e      fill_q, fill_d;
    logic [7:0] y_q, y_d;
    logic [7:0] word_q, word_d;
    logic       done_q, done_d;
    logic [2:0] lane;

    always_comb begin
        lane   = auto ? fill_q : s;
        y_d    = y_q;
        fill_d = fill_q;
        word_d = word_q;
        done_d = 1'b0;
        if (clr) begin
            y_d    = CLR_VAL;
            fill_d = FILL_0;
        end else if (en) begin
            y_d[lane] = d;
            if (auto) begin
                fill_d = fill_e'(fill_q + 3'd1);
                // The eighth bit is bypassed straight into the completed word.
                if (fill_q == FILL_7) begin
                    word_d = {d, y_q[6:0]};
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= CLR_VAL;
            word_q <= 8'h00;
            fill_q <= FILL_0;
            done_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            word_q <= word_d;
            fill_q <= fill_d;
            done_q <= done_d;
        end
    end

    assign y    = y_q;
    assign cnt  = fill_q;
    assign q    = word_q;
    assign done = done_q;

endmodule

// File: tb/tb_demux_18.sv
// Scoreboarded testbench for demux_18: a lane/word model predicts every cycle,
// a monitor on the falling edge pops and compares.
module tb_demux_18;

    localparam logic [7:0] CLR_VAL = 8'h00;

    logic       clk = 1'b0;
    logic       rst, clr, en, auto, d;
    logic [2:0] s;
    logic [7:0] y, q;
    logic [2:0] cnt;
    logic       done;

    typedef struct {
        logic [7:0] y;
        logic [2:0] cnt;
        logic [7:0] q;
        logic       done;
    } exp_t;

    exp_t sb[$];

    int tests    = 0;
    int failures = 0;

    logic [7:0] mY;
    logic [7:0] mQ;
    int         mCnt;
    logic       mDone;
    bit         modelValid = 0;

    demux_18 #(.CLR_VAL(CLR_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .auto(auto),
        .s   (s),
        .d   (d),
        .y   (y),
        .cnt (cnt),
        .q   (q),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check("y", y, e.y);
        check("cnt", {5'd0, cnt}, {5'd0, e.cnt});
        check("q", q, e.q);
        check("done", {7'd0, done}, {7'd0, e.done});
    endtask

    // The monitor sees one prediction per clock edge, offset by half a period.
    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    task automatic applyStimulus(input logic r, input logic c, input logic e,
                                 input logic a, input logic [2:0] sv, input logic dv);
        int lane;
        rst = r; clr = c; en = e; auto = a; s = sv; d = dv;
        if (r) begin
            mY = CLR_VAL; mQ = 8'h00; mCnt = 0; mDone = 1'b0; modelValid = 1;
        end else if (c) begin
            mY = CLR_VAL; mCnt = 0; mDone = 1'b0;
        end else if (e) begin
            lane = a ? mCnt : int'(sv);
            mY[lane] = dv;
            mDone = 1'b0;
            if (a) begin
                if (mCnt == 7) begin
                    mQ = mY;
                    mDone = 1'b1;
                end
                mCnt = (mCnt + 1) % 8;
            end
        end else begin
            mDone = 1'b0;
        end
        if (modelValid) sb.push_back('{mY, 3'(mCnt), mQ, mDone});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 3'($urandom), 1'($urandom));
    endtask

    task automatic feedWord(input logic [7:0] w, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 1, 3'($urandom), w[i]);
            if (gaps) applyStimulus(0, 0, 0, 1, 3'($urandom), 1'($urandom));
        end
    endtask

    function automatic logic mux8(input logic [7:0] v, input logic [2:0] sel);
        return v[sel];
    endfunction

    initial begin
        int waitCycles;
        logic [7:0] pattern;
        rst = 0; clr = 0; en = 0; auto = 0; s = 0; d = 0;

        // Reset with junk on the other inputs, then hold.
        applyStimulus(1, 1, 1, 1, 3'd6, 1);
        applyStimulus(1, 0, 1, 0, 3'd3, 1);
        idle(3);

        // Addressed writes: lane 5 then lane 0.
        applyStimulus(0, 0, 1, 0, 3'd5, 1);
        applyStimulus(0, 0, 1, 0, 3'd0, 1);
        idle(1);

        // Counter words: contiguous, with gaps, then an all-ones word back to back.
        applyStimulus(1, 0, 0, 0, 3'd0, 0);
        feedWord(8'h4D, 0);
        idle(2);
        feedWord(8'h4D, 1);
        feedWord(8'hFF, 0);
        feedWord(8'h96, 0);
        idle(2);

        // Clear mid-word, then clear and reset on a completing accept.
        feedWord(8'h00, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 3'd0, 1);
        applyStimulus(0, 1, 1, 1, 3'd0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 1, 3'd0, 1);
        applyStimulus(0, 1, 1, 1, 3'd0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 1, 3'd0, 0);
        applyStimulus(1, 0, 1, 1, 3'd0, 1);
        idle(1);

        // Mode switch mid-word: addressed writes leave the counter alone.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 3'd0, 1);
        applyStimulus(0, 0, 1, 0, 3'd1, 0);
        applyStimulus(0, 0, 1, 0, 3'd7, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 3'd0, 0);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                          1'($urandom), ($urandom_range(0, 3) != 0),
                          3'($urandom), 1'($urandom));

        // Loopback sweep through a downstream 8:1 mux, with a reset partway.
        for (int j = 0; j < 256; j++) begin
            pattern = 8'(j);
            for (int b = 0; b < 8; b++) applyStimulus(0, 0, 1, 0, 3'(b), pattern[b]);
            for (int sel = 0; sel < 8; sel++)
                check("mux", {7'd0, mux8(y, 3'(sel))}, 8'((j >> sel) & 1));
            if (j == 128) begin
                applyStimulus(1, 0, 0, 0, 3'd0, 0);
                for (int sel = 0; sel < 8; sel++)
                    check("mux_rst", {7'd0, mux8(y, 3'(sel))}, 8'h00);
            end
        end

        waitCycles = 0;
        while (sb.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        #1;
        tests++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/demux_18.md
# demux_18

Registered 1-to-8 demultiplexer and bit-serial word assembler, the receiving end of the 8:1 select path. A single data bit is steered into one of eight lane registers, either by an explicit 3-bit select or by an internal wrapping lane counter. In counter mode, eight accepted bits form a completed byte, presented with a one-cycle done pulse. It sits downstream of any 8:1 mux-based serializer in the datapath and restores the parallel word.

## Interface
- CLR_VAL, 8'h00, value loaded into lane register `y` on reset and on `clr`
- clk  input  1  rising-edge clock; the single clock for the block
- rst  input  1  reset, synchronous, active-high; highest priority
- clr  input  1  synchronous clear of `y` and `cnt`; priority below `rst`, above `en`
- en  input  1  accept qualifier; `d` is written only in cycles where `en`=1
- auto  input  1  0 = addressed mode (lane = `s`); 1 = counter mode (lane = `cnt`)
- s  input  3  lane select in addressed mode; ignored when `auto`=1
- d  input  1  serial data bit
- y  output  8  lane registers, updated bit-wise
- cnt  output  3  current auto lane index
- q  output  8  last completed word, counter mode only
- done  output  1  one-cycle pulse: `q` was updated this cycle

## Operation
- Priority per rising edge: `rst` > `clr` > `en` > hold.
- `rst`=1: `y`<=CLR_VAL, `q`<=8'h00, `cnt`<=0, `done`<=0.
- `clr`=1 (no `rst`): `y`<=CLR_VAL, `cnt`<=0, `done`<=0; `q` holds. A partial word is discarded.
- Addressed accept (`en`=1, `auto`=0): `y[s]`<=`d`; the other seven bits hold; `cnt` holds; `done`<=0.
- Counter accept (`en`=1, `auto`=1):
  - `y[cnt]`<=`d`; the other bits hold.
  - `cnt`<=`cnt`+1, mod 8 (7 wraps to 0).
- Word completion: a counter accept with `cnt`=7 produces:
  - `q`<=`y` with bit 7 replaced by `d`, so the 8th bit is bypassed into `q` in the same edge.
  - `done`<=1.
- Any other cycle: `done`<=0; `q` holds.
- Counter states:
  - FILL_k (`cnt`=k, k=0..7).
  - Transitions occur only on counter accepts: FILL_k -> FILL_(k+1); FILL_7 -> FILL_0 with done.
- `en`=0: `y`, `cnt` and `q` hold; `done`<=0.
- Mode switch mid-word: `cnt` is neither cleared nor advanced while `auto`=0. Addressed writes can overwrite lanes of a partial word. Resuming `auto`=1 continues from the held `cnt`.
- Unknown or unused select values: none. All 8 codes are valid and there is no default/high-Z output.

## Timing
- Write latency: 1 cycle. `d`/`s` sampled at edge N are visible on `y` after edge N.
- `done` is high during the cycle after the edge that accepted the 8th bit, for exactly one cycle.
- `q` changes on that same edge and holds until the next completion.
- Back-to-back words with `en` held high:
  - `done` every 8th cycle, with no dead cycle between words.
  - FILL_7 -> FILL_0 and the first bit of the next word are accepted on consecutive edges.
- `clr` or `rst` in the same cycle as a completing accept: the clear wins, with no `done` and `q` unchanged (`rst` additionally zeroes `q`).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: drive junk inputs, `rst`=1 for 2 cycles -> `y`=8'h00, `q`=8'h00, `cnt`=0, `done`=0; after release with `en`=0, all hold.
- Addressed write: `auto`=0, `en`=1, `s`=5, `d`=1, then `s`=0, `d`=1 -> `y`=8'h20, then 8'h21; `cnt`=0 and `done`=0 throughout.
- Counter word: `auto`=1, `en`=1, bits d=1,0,1,1,0,0,1,0 on consecutive cycles (bit 0 first) -> `q`=8'h4D, `done`=1 for exactly one cycle after the 8th edge, `cnt`=0.
- Gaps and back-to-back:
  - The same bits with `en` toggled 1/0 -> identical `q`=8'h4D, with `cnt` holding through the `en`=0 cycles.
  - A second word, all 1s, streamed immediately after -> `q`=8'hFF with `done` exactly 8 cycles after the first `done`.
- Clear mid-word: after 3 counter accepts, `clr`=1 -> `cnt`=0, `y`=CLR_VAL, no `done`, `q` keeps its previous value; also assert `clr` on a completing accept -> `done` stays 0.
- Loopback sweep: for j=0..255, write j into `y` via addressed mode, then feed `y` into the 8:1 mux with `s` swept 0..7 -> the mux output equals bit s of j every time; reset mid-sweep restores all zeros.
